// File: rtl/shift_reg_univ.sv
// Universal shift register: shift/rotate/load with a counted burst engine.
// Ports: clk, rst (async low), en, mode, sin_l, sin_r, pdata, start, nshift -> q, sout, busy, done.
module shift_reg_univ #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] nshift,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LD   = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(WIDTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] count, count_d, nsat;
  logic [2:0]       mode_r, mode_d, op;
  logic [WIDTH-1:0] q_d;
  logic             sout_d, done_d;
  logic             burst_mode;

  assign burst_mode = (mode == M_SHL) || (mode == M_SHR) ||
                      (mode == M_ROL) || (mode == M_ROR);

  assign nsat = (nshift > C_MAX) ? C_MAX : nshift;

  assign busy = (state == BUSY);

  // Control: picks the operation executed this edge and
  // sequences the burst counter.
  always_comb begin
    state_d = state;
    count_d = count;
    mode_d  = mode_r;
    done_d  = 1'b0;
    op      = M_HOLD;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (start && burst_mode) begin
            mode_d  = mode;
            count_d = nsat;
            if (nsat != '0) begin
              // first shift of the burst happens on the start edge
              op      = mode;
              count_d = nsat - C_ONE;
              if (nsat == C_ONE) done_d = 1'b1;
              else               state_d = BUSY;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            op = mode;
          end
        end
        BUSY: begin
          op      = mode_r;
          count_d = count - C_ONE;
          if (count == C_ONE) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath
  always_comb begin
    q_d    = q;
    sout_d = sout;
    unique case (1'b1)
      (op == M_SHL): begin
        q_d    = {q[WIDTH-2:0], sin_l};
        sout_d = q[WIDTH-1];
      end
      (op == M_SHR): begin
        q_d    = {sin_r, q[WIDTH-1:1]};
        sout_d = q[0];
      end
      (op == M_ROL): begin
        q_d    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_d = q[WIDTH-1];
      end
      (op == M_ROR): begin
        q_d    = {q[0], q[WIDTH-1:1]};
        sout_d = q[0];
      end
      (op == M_LD): q_d = pdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q      <= '0;
      sout   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      mode_r <= M_HOLD;
      state  <= IDLE;
    end else begin
      q      <= q_d;
      sout   <= sout_d;
      done   <= done_d;
      count  <= count_d;
      mode_r <= mode_d;
      state  <= state_d;
    end
  end

endmodule
